multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller:
// FSM states, ALU/immediate/result/source select codes and opcodes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr1,
    StJalr2,
    StLui
  } state_e;

  // Coarse ALU request from the FSM; AluOpFunct defers to funct3/funct7b5.
  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResImm       = 2'b11;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// write enables and mux selects out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;

  modport master (
    input  op, funct3, funct7b5, zero, lt,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's coarse ALU request plus funct
// fields onto the ALUControl encoding.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       sub_en,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    unique case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          3'b000:  alu_control = sub_en ? AluSub : AluAdd;
          3'b111:  alu_control = AluAnd;
          3'b110:  alu_control = AluOr;
          3'b100:  alu_control = AluXor;
          3'b010:  alu_control = AluSlt;
          3'b011:  alu_control = AluSltu;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style main FSM of a multicycle RV32I core; drives datapath enables
// and selects, with all outputs held low while reset is asserted.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic [2:0] alu_control;
  logic       branch_taken;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] src_a, src_b, result_src;
  logic [2:0] imm_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr1;
          OpLui:           state_d = StLui;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StJalr1:    state_d = StJalr2;
      StJalr2:    state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  branch_taken = bus.zero;
      3'b001:  branch_taken = !bus.zero;
      3'b100:  branch_taken = bus.lt;
      3'b101:  branch_taken = !bus.lt;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    src_a      = SrcAPc;
    src_b      = SrcBRs2;
    result_src = ResAluOut;
    imm_src    = ImmI;
    alu_op     = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        src_b      = SrcBFour;
        result_src = ResAluResult;
      end
      StDecode: begin
        src_a   = SrcAOldPc;
        src_b   = SrcBImm;
        imm_src = (bus.op == OpJal) ? ImmJ : ImmB;
      end
      StMemAdr: begin
        src_a   = SrcARs1;
        src_b   = SrcBImm;
        imm_src = (bus.op == OpStore) ? ImmS : ImmI;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        src_a  = SrcARs1;
        alu_op = AluOpFunct;
      end
      StExecI: begin
        src_a  = SrcARs1;
        src_b  = SrcBImm;
        alu_op = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StBranch: begin
        src_a    = SrcARs1;
        alu_op   = AluOpSub;
        pc_write = branch_taken;
      end
      StJal, StJalr2: begin
        src_a    = SrcAOldPc;
        src_b    = SrcBFour;
        pc_write = 1'b1;
      end
      StJalr1: begin
        src_a = SrcARs1;
        src_b = SrcBImm;
      end
      StLui: begin
        imm_src    = ImmU;
        result_src = ResImm;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // funct7b5 selects subtract only for register-register ops, never addi.
  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .sub_en      (bus.funct7b5 && (state_q == StExecR)),
    .alu_control (alu_control)
  );

  assign bus.PCWrite    = !rst && pc_write;
  assign bus.IRWrite    = !rst && ir_write;
  assign bus.RegWrite   = !rst && reg_write;
  assign bus.MemWrite   = !rst && mem_write;
  assign bus.AdrSrc     = !rst && adr_src;
  assign bus.ALUSrcA    = rst ? 2'b00 : src_a;
  assign bus.ALUSrcB    = rst ? 2'b00 : src_b;
  assign bus.ResultSrc  = rst ? 2'b00 : result_src;
  assign bus.ALUControl = rst ? 3'b000 : alu_control;
  assign bus.ImmSrc     = rst ? 3'b000 : imm_src;

endmodule
